// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg: shared widths, register count and writeback winner type
package rf_ctrl_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;
  localparam int REG_N = 2 ** DEF_ADDR_W;
  typedef enum logic {WIN_ALU = 1'b0, WIN_MEM = 1'b1} win_e;
endpackage

// File: rtl/rf_wb_arb_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with combinational grants
// Ports: clk, rst (async, active-low); alu_req/mem_req in; alu_gnt/mem_gnt out.
// The pointer names the requester that wins the next tie; it starts on mem.
module rr_arb2
  import rf_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic alu_req,
  input  logic mem_req,
  output logic alu_gnt,
  output logic mem_gnt
);
  win_e fav;
  always_comb begin
    alu_gnt = rst & alu_req & (~mem_req | (fav == WIN_ALU));
    mem_gnt = rst & mem_req & (~alu_req | (fav == WIN_MEM));
  end
  // after a transfer the loser becomes favoured
  always_ff @(posedge clk or negedge rst)
    if (!rst) fav <= WIN_MEM;
    else if (alu_gnt | mem_gnt) fav <= alu_gnt ? WIN_MEM : WIN_ALU;
endmodule

// File: rtl/rf_wb_arb.sv
// rf_wb_arb: register-file writeback arbiter with busy-bit scoreboard
// Ports: clk, rst (async, active-low); alu_*/mem_* writeback requests with
// combinational grants; write/writeregsel/writedata registered RF write port;
// iss_valid/iss_regsel mark a destination pending; rdN_chk/rdN_sel operands
// checked for stall; err is a sticky spurious-writeback flag.
// Macro RF_WB_FWD_EN adds rdN_fwd/rdN_fwddata bypass outputs.
module rf_wb_arb
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_req,
  input  logic [ADDR_W-1:0] alu_regsel,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] mem_regsel,
  input  logic [DATA_W-1:0] mem_data,
  output logic              alu_gnt,
  output logic              mem_gnt,
  output logic              write,
  output logic [ADDR_W-1:0] writeregsel,
  output logic [DATA_W-1:0] writedata,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_regsel,
  input  logic              rd1_chk,
  input  logic              rd2_chk,
  input  logic [ADDR_W-1:0] rd1_sel,
  input  logic [ADDR_W-1:0] rd2_sel,
  output logic              stall,
  output logic              err
`ifdef RF_WB_FWD_EN
  ,
  output logic              rd1_fwd,
  output logic              rd2_fwd,
  output logic [DATA_W-1:0] rd1_fwddata,
  output logic [DATA_W-1:0] rd2_fwddata
`endif
);
  localparam int NREG = 1 << ADDR_W;
  logic            xfer;
  logic [NREG-1:0] busy, set, clr;
  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .alu_req(alu_req),
    .mem_req(mem_req),
    .alu_gnt(alu_gnt),
    .mem_gnt(mem_gnt)
  );
  assign xfer = alu_gnt | mem_gnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      write       <= 1'b0;
      writeregsel <= '0;
      writedata   <= '0;
    end else begin
      write <= xfer;
      if (xfer) begin
        writeregsel <= alu_gnt ? alu_regsel : mem_regsel;
        writedata   <= alu_gnt ? alu_data : mem_data;
      end
    end
  // set is applied after clear so a new producer wins a same-edge collision
  always_comb begin
    set = iss_valid ? NREG'(1) << iss_regsel : '0;
    clr = write ? NREG'(1) << writeregsel : '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      busy <= '0;
      err  <= 1'b0;
    end else begin
      busy <= (busy & ~clr) | set;
      err  <= err | (write & ~busy[writeregsel]);
    end
`ifdef RF_WB_FWD_EN
  // an operand matching the retiring write is bypassed instead of stalled
  always_comb begin
    rd1_fwd     = write & rd1_chk & (writeregsel == rd1_sel);
    rd2_fwd     = write & rd2_chk & (writeregsel == rd2_sel);
    rd1_fwddata = writedata;
    rd2_fwddata = writedata;
    stall       = (rd1_chk & busy[rd1_sel] & ~rd1_fwd) | (rd2_chk & busy[rd2_sel] & ~rd2_fwd);
  end
`else
  assign stall = (rd1_chk & busy[rd1_sel]) | (rd2_chk & busy[rd2_sel]);
`endif
endmodule

// File: tb/tb_rf_wb_arb.sv
// tb_rf_wb_arb: scoreboard bench with directed scenarios and random traffic
module tb_rf_wb_arb;
  localparam int DW = 16, AW = 3, NR = 8;
  logic clk = 0, rst = 0;
  logic alu_req = 0, mem_req = 0, iss_valid = 0, rd1_chk = 0, rd2_chk = 0;
  logic [AW-1:0] alu_regsel = 0, mem_regsel = 0, iss_regsel = 0, rd1_sel = 0, rd2_sel = 0;
  logic [DW-1:0] alu_data = 0, mem_data = 0;
  logic alu_gnt, mem_gnt, write, stall, err;
  logic [AW-1:0] writeregsel;
  logic [DW-1:0] writedata;
`ifdef RF_WB_FWD_EN
  logic rd1_fwd, rd2_fwd;
  logic [DW-1:0] rd1_fwddata, rd2_fwddata;
`endif
  rf_wb_arb dut (
    .clk(clk), .rst(rst),
    .alu_req(alu_req), .alu_regsel(alu_regsel), .alu_data(alu_data),
    .mem_req(mem_req), .mem_regsel(mem_regsel), .mem_data(mem_data),
    .alu_gnt(alu_gnt), .mem_gnt(mem_gnt),
    .write(write), .writeregsel(writeregsel), .writedata(writedata),
    .iss_valid(iss_valid), .iss_regsel(iss_regsel),
    .rd1_chk(rd1_chk), .rd2_chk(rd2_chk), .rd1_sel(rd1_sel), .rd2_sel(rd2_sel),
    .stall(stall), .err(err)
`ifdef RF_WB_FWD_EN
    , .rd1_fwd(rd1_fwd), .rd2_fwd(rd2_fwd), .rd1_fwddata(rd1_fwddata), .rd2_fwddata(rd2_fwddata)
`endif
  );
  always #5 clk = ~clk;

  typedef struct packed {logic [AW-1:0] sel; logic [DW-1:0] data;} wr_t;
  wr_t q[$];
  wr_t e;
  bit busy_m[NR];
  bit err_m = 0, mem_turn = 1, pend_v = 0, wa, eag, emg, s1, s2, f1, f2;
  logic [AW-1:0] pend_sel = 0;
  int n_chk = 0, n_fail = 0;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
    end
  endfunction

  // reference model: expected writes, busy set and sticky error flag
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      q.delete();
      foreach (busy_m[i]) busy_m[i] = 0;
      err_m = 0; mem_turn = 1; pend_v = 0;
    end else begin
      if (pend_v) begin
        if (!busy_m[pend_sel]) err_m = 1;
        busy_m[pend_sel] = 0;
      end
      if (iss_valid) busy_m[iss_regsel] = 1;
      pend_v = 0;
      if (alu_req || mem_req) begin
        wa = alu_req && (!mem_req || !mem_turn);
        e = wa ? '{alu_regsel, alu_data} : '{mem_regsel, mem_data};
        q.push_back(e);
        pend_v = 1;
        pend_sel = e.sel;
        mem_turn = wa;
      end
    end
  end

  // monitor: compares DUT outputs against the model every cycle
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("rst_write", write, 0);
      chk("rst_gnt", {alu_gnt, mem_gnt}, 0);
    end else begin
      eag = alu_req && (!mem_req || !mem_turn);
      emg = mem_req && (!alu_req || mem_turn);
      chk("alu_gnt", alu_gnt, eag);
      chk("mem_gnt", mem_gnt, emg);
      chk("write", write, q.size() > 0);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (write) begin
          chk("writeregsel", writeregsel, e.sel);
          chk("writedata", writedata, e.data);
        end
      end
      s1 = rd1_chk && busy_m[rd1_sel];
      s2 = rd2_chk && busy_m[rd2_sel];
      f1 = pend_v && rd1_chk && pend_sel == rd1_sel;
      f2 = pend_v && rd2_chk && pend_sel == rd2_sel;
`ifdef RF_WB_FWD_EN
      chk("rd1_fwd", rd1_fwd, f1);
      chk("rd2_fwd", rd2_fwd, f2);
      if (f1) chk("rd1_fwddata", rd1_fwddata, writedata);
      s1 = s1 && !f1;
      s2 = s2 && !f2;
`endif
      chk("stall", stall, s1 || s2);
      chk("err", err, err_m);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    alu_req = 0; mem_req = 0; iss_valid = 0; rd1_chk = 0; rd2_chk = 0;
  endtask
  task automatic do_reset();
    rst = 0;
    idle();
    repeat (2) tick();
    rst = 1;
    tick();
  endtask

  initial begin
    repeat (2) tick();
    chk("reset_write", write, 0);
    chk("reset_sel", writeregsel, 0);
    chk("reset_data", writedata, 0);
    chk("reset_err", err, 0);
    rst = 1;
    tick();
    // lone alu request
    alu_req = 1; alu_regsel = 3; alu_data = 16'h1234;
    #1 chk("lone_gnt", alu_gnt, 1);
    tick();
    alu_req = 0;
    #1 chk("lone_write", write, 1);
    chk("lone_sel", writeregsel, 3);
    chk("lone_data", writedata, 16'h1234);
    tick();
    chk("lone_write_drop", write, 0);
    chk("lone_sel_hold", writeregsel, 3);
    do_reset();
    // both requesting: mem, alu, mem, alu
    alu_req = 1; alu_regsel = 1; alu_data = 16'hA1;
    mem_req = 1; mem_regsel = 2; mem_data = 16'hB2;
    for (int i = 0; i < 4; i++) begin
      #1 chk("rr_mem", mem_gnt, i % 2 == 0);
      chk("rr_alu", alu_gnt, i % 2 == 1);
      if (i > 0) chk("rr_wsel", writeregsel, (i % 2 == 1) ? 2 : 1);
      tick();
    end
    idle();
    chk("rr_last", writeregsel, 1);
    do_reset();
    // hazard on register 5
    iss_valid = 1; iss_regsel = 5;
    tick();
    iss_valid = 0; rd1_chk = 1; rd1_sel = 5;
    #1 chk("haz_stall0", stall, 1);
    tick();
    mem_req = 1; mem_regsel = 5; mem_data = 16'h5555;
    #1 chk("haz_gnt", mem_gnt, 1);
    chk("haz_stall1", stall, 1);
    tick();
    mem_req = 0;
`ifdef RF_WB_FWD_EN
    #1 chk("haz_stall_wr", stall, 0);
    chk("haz_fwd", rd1_fwd, 1);
`else
    #1 chk("haz_stall_wr", stall, 1);
`endif
    tick();
    chk("haz_clear", stall, 0);
    idle();
    do_reset();
    // spurious writeback to register 2
    alu_req = 1; alu_regsel = 2; alu_data = 16'h22;
    tick();
    idle();
    chk("spur_err0", err, 0);
    tick();
    chk("spur_err1", err, 1);
    repeat (3) tick();
    chk("spur_sticky", err, 1);
    rst = 0;
    #1 chk("spur_rst", err, 0);
    tick();
    rst = 1;
    tick();
    // issue and retire on register 4 at the same edge
    iss_valid = 1; iss_regsel = 4;
    tick();
    iss_valid = 0; alu_req = 1; alu_regsel = 4; alu_data = 16'h44;
    tick();
    alu_req = 0; iss_valid = 1; iss_regsel = 4;
    tick();
    iss_valid = 0; rd1_chk = 1; rd1_sel = 4;
    #1 chk("same_busy", stall, 1);
    chk("same_err", err, 0);
    idle();
    do_reset();
    // asynchronous reset mid-transfer
    iss_valid = 1; iss_regsel = 1;
    tick();
    iss_valid = 0; alu_req = 1; alu_regsel = 1; alu_data = 16'h55;
    tick();
    alu_req = 0; rd1_chk = 1; rd1_sel = 1;
    #1 chk("mid_write", write, 1);
    #1 rst = 0;
    #1 chk("mid_write_drop", write, 0);
    chk("mid_busy", stall, 0);
    alu_req = 1;
    #1 chk("mid_gnt", alu_gnt, 0);
    alu_req = 0;
    tick();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("mid_no_write", write, 0);
      tick();
    end
    idle();
    do_reset();
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (i % 97 == 96) do_reset();
      else begin
        alu_req = $urandom_range(0, 1); mem_req = $urandom_range(0, 1);
        alu_regsel = AW'($urandom); mem_regsel = AW'($urandom);
        alu_data = DW'($urandom); mem_data = DW'($urandom);
        iss_valid = $urandom_range(0, 1); iss_regsel = AW'($urandom);
        rd1_chk = $urandom_range(0, 1); rd2_chk = $urandom_range(0, 1);
        rd1_sel = AW'($urandom); rd2_sel = AW'($urandom);
        tick();
      end
    end
    idle();
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
